iot_event_arbiter: RTL and testbench

- Serialises connect/disconnect events from N_DEV IoT device ports onto the single change/on_off command interface of the active-device counter (monitor).
- Shares the counter between requesters using round-robin arbitration and a 4-phase req/ack handshake.
- Tracks each device's active state and rejects redundant events, so that every change pulse it issues corresponds to exactly one real state transition.
- Sits between the device-facing link logic and the monitor counter.

---
 rtl/iot_event_arbiter.sv | 107 ++++++++++
 tb/tb_iot_event_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/iot_event_arbiter.sv
// iot_event_arbiter: round-robin serialiser of device connect/disconnect events onto a shared monitor counter
// Optional build macro IOT_ARB_DUP_CNT_EN adds a saturating counter of rejected events on dup_cnt.
module iot_event_arbiter #(
    parameter int N_DEV = 4,
    parameter int CNT_W = 8,
    parameter int IDX_W = $clog2(N_DEV)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_DEV-1:0] req,
    input  logic [N_DEV-1:0] req_on,
    output logic [N_DEV-1:0] ack,
    output logic             change,
    output logic             on_off,
    output logic [N_DEV-1:0] active_map,
    output logic [CNT_W-1:0] active_cnt,
    output logic             rej,
    output logic             busy,
    output logic [7:0]       dup_cnt
);
    typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_t;
    state_t state, state_nx;
    logic [IDX_W-1:0] rr_ptr, gidx, sel, idx;
    logic gdir, found, valid, ack_up, release_req;
    assign ack_up = |ack;
    assign release_req = ack_up && !req[gidx];
    assign valid = gdir ? (!active_map[gidx] && active_cnt != '1)
                        : (active_map[gidx] && active_cnt != '0);
    // circular search for the first requester at or after rr_ptr
    always_comb begin
        sel = '0;
        found = 1'b0;
        idx = '0;
        for (int k = 0; k < N_DEV; k++) begin
            idx = IDX_W'((int'(rr_ptr) + k) % N_DEV);
            if (!found && req[idx]) begin
                found = 1'b1;
                sel = idx;
            end
        end
    end
    // next-state: one ISSUE cycle per grant, ACK held until the requester releases
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = found ? ISSUE : IDLE;
            ISSUE:   state_nx = ACK;
            ACK:     state_nx = release_req ? IDLE : ACK;
            default: state_nx = IDLE;
        endcase
    end
    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end
    // registered outputs, grant latch, active tracking and round-robin pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack        <= '0;
            change     <= 1'b0;
            on_off     <= 1'b0;
            active_map <= '0;
            active_cnt <= '0;
            rej        <= 1'b0;
            busy       <= 1'b0;
            rr_ptr     <= '0;
            gidx       <= '0;
            gdir       <= 1'b0;
        end else begin
            change <= 1'b0;
            rej    <= 1'b0;
            busy   <= state_nx != IDLE;
            if (state == IDLE && found) begin
                gidx <= sel;
                gdir <= req_on[sel];
            end
            if (state == ISSUE) begin
                if (valid) begin
                    change           <= 1'b1;
                    on_off           <= gdir;
                    active_map[gidx] <= !active_map[gidx];
                    active_cnt       <= gdir ? active_cnt + CNT_W'(1) : active_cnt - CNT_W'(1);
                end else begin
                    rej <= 1'b1;
                end
            end
            if (state == ACK) begin
                if (!ack_up) begin
                    ack <= N_DEV'(1) << gidx;
                end else if (!req[gidx]) begin
                    ack    <= '0;
                    rr_ptr <= (int'(gidx) == N_DEV - 1) ? '0 : gidx + IDX_W'(1);
                end
            end
        end
    end
`ifdef IOT_ARB_DUP_CNT_EN
    // saturating count of rejected events
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                        dup_cnt <= '0;
        else if (state == ISSUE && !valid && dup_cnt != 8'hFF) dup_cnt <= dup_cnt + 8'd1;
    end
`else
    assign dup_cnt = '0;
`endif
endmodule

// File: tb/tb_iot_event_arbiter.sv
// tb_iot_event_arbiter: randomized bursts checked against a transaction-level model of the arbiter
module tb_iot_event_arbiter;
    localparam int N  = 4;
    localparam int CW = 8;
    logic clk = 1'b0;
    logic rst;
    logic [N-1:0] req = '0, req_on = '0;
    logic [N-1:0] ack, active_map;
    logic change, on_off, rej, busy;
    logic [CW-1:0] active_cnt;
    logic [7:0] dup_cnt;

    iot_event_arbiter #(.N_DEV(N), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .req(req), .req_on(req_on), .ack(ack),
        .change(change), .on_off(on_off), .active_map(active_map),
        .active_cnt(active_cnt), .rej(rej), .busy(busy), .dup_cnt(dup_cnt)
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    bit [N-1:0] m_map;
    int m_cnt, m_ptr, m_dup, mon_cnt;
    int last_chg = -1;
    int exp_idx[$], exp_res[$], obs_idx[$], obs_res[$];
    logic [N-1:0] prev_ack = '0;
    bit got_res, got_ack;

    function automatic int dup_exp();
`ifdef IOT_ARB_DUP_CNT_EN
        return m_dup;
`else
        return 0;
`endif
    endfunction

    task automatic model_clear();
        m_map = '0; m_cnt = 0; m_ptr = 0; m_dup = 0; mon_cnt = 0;
        exp_idx.delete(); exp_res.delete(); obs_idx.delete(); obs_res.delete();
    endtask

    // result code: 0 = rejected, 1 = count up, 2 = count down
    task automatic expect_burst(input bit [N-1:0] mask, input bit [N-1:0] on);
        bit [N-1:0] pend;
        int pick;
        bit ok;
        pend = mask;
        while (pend != 0) begin
            pick = -1;
            for (int k = 0; k < N; k++)
                if (pick < 0 && pend[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
            ok = on[pick] ? (!m_map[pick] && m_cnt < (1 << CW) - 1) : (m_map[pick] && m_cnt > 0);
            if (ok) begin
                m_map[pick] = ~m_map[pick];
                m_cnt += on[pick] ? 1 : -1;
                exp_res.push_back(on[pick] ? 1 : 2);
            end else begin
                exp_res.push_back(0);
                if (m_dup < 255) m_dup++;
            end
            exp_idx.push_back(pick);
            pend[pick] = 1'b0;
            m_ptr = (pick + 1) % N;
        end
    endtask

    task automatic sample(input int n, input bit lat);
        int id;
        if (change || rej) begin
            obs_res.push_back(rej ? 0 : (on_off ? 1 : 2));
            if (lat && !got_res) check("lat_change", n, 2);
            got_res = 1'b1;
        end
        if (change) begin
            if (last_chg >= 0) check("chg_gap_ge4", int'(cyc - last_chg >= 4), 1);
            last_chg = cyc;
            mon_cnt += on_off ? 1 : -1;
        end
        if (ack != 0 && prev_ack == 0) begin
            id = -1;
            if ($onehot(ack))
                for (int i = 0; i < N; i++) if (ack[i]) id = i;
            obs_idx.push_back(id);
            if (lat && !got_ack) check("lat_ack", n, 3);
            got_ack = 1'b1;
        end
        prev_ack = ack;
    endtask

    task automatic wait_done(input bit lat);
        int n;
        bit done;
        n = 0; done = 1'b0; got_res = 1'b0; got_ack = 1'b0;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
            sample(n, lat);
            for (int i = 0; i < N; i++) if (req[i] && ack[i]) req[i] = 1'b0;
            if (req == 0 && !busy && ack == 0) done = 1'b1;
        end
        check("done_in_time", int'(done), 1);
        for (int k = 0; k < exp_idx.size(); k++) begin
            check("grant_idx", k < obs_idx.size() ? obs_idx[k] : -1, exp_idx[k]);
            check("result", k < obs_res.size() ? obs_res[k] : -1, exp_res[k]);
        end
        check("n_grants", obs_idx.size(), exp_idx.size());
        check("n_results", obs_res.size(), exp_res.size());
        check("active_map", int'(active_map), int'(m_map));
        check("active_cnt", int'(active_cnt), m_cnt);
        check("monitor_cnt", mon_cnt, m_cnt);
        check("dup_cnt", int'(dup_cnt), dup_exp());
        exp_idx.delete(); exp_res.delete(); obs_idx.delete(); obs_res.delete();
    endtask

    task automatic burst(input bit [N-1:0] mask, input bit [N-1:0] on);
        expect_burst(mask, on);
        req_on = on;
        req = mask;
        wait_done(1'b1);
    endtask

    task automatic do_reset();
        req = '1;
        req_on = N'($urandom);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("rst_change", int'(change), 0);
            check("rst_ack", int'(ack), 0);
            check("rst_cnt", int'(active_cnt), 0);
            check("rst_map", int'(active_map), 0);
            check("rst_busy", int'(busy), 0);
        end
        req = '0;
        rst = 1'b1;
        model_clear();
    endtask

    initial begin
        rst = 1'b1;
        #1;
        do_reset();
        burst(4'b0100, 4'b0100);
        do_reset();
        burst(4'b1011, 4'b1111);
        do_reset();
        burst(4'b0001, 4'b0001);
        burst(4'b0001, 4'b0001);
        burst(4'b1000, 4'b0000);
        burst(4'b0010, 4'b0010);
        burst(4'b0010, 4'b0000);
        repeat (40) burst(N'($urandom_range(1, 15)), N'($urandom_range(0, 15)));
        do_reset();
        req_on = 4'b0001;
        req = 4'b0001;
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_change", int'(change), 0);
        check("mid_rst_ack", int'(ack), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_map", int'(active_map), 0);
        check("mid_rst_cnt", int'(active_cnt), 0);
        check("mid_rst_rej", int'(rej), 0);
        check("mid_rst_on_off", int'(on_off), 0);
        repeat (3) begin
            @(negedge clk);
            check("mid_rst_no_change", int'(change), 0);
            check("mid_rst_idle", int'(busy), 0);
        end
        model_clear();
        rst = 1'b1;
        expect_burst(4'b0001, 4'b0001);
        wait_done(1'b0);
        repeat (10) burst(N'($urandom_range(1, 15)), N'($urandom_range(0, 15)));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
